// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds, sticky error flags,
// flush, and selectable registered or first-word-fall-through read data.
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  read_en,
    input  logic [CW-1:0]         af_level,
    input  logic [CW-1:0]         ae_level,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic                  amst_full,
    output logic                  amst_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  amst_full_q, amst_full_d, amst_empty_q, amst_empty_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  ptr_full, ptr_empty, do_wr, do_rd;

    always_comb begin
        // Pointers differ only in the wrap bit exactly when every entry is occupied.
        ptr_full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
        ptr_empty = (wr_ptr_q == rd_ptr_q);
        do_wr     = write_en && !ptr_full && !flush;
        do_rd     = read_en && !ptr_empty && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        full_d       = (count_d == DEPTH_C);
        empty_d      = (count_d == '0);
        amst_full_d  = (count_d >= af_level);
        amst_empty_d = (count_d <= ae_level);

        // A new error event in the same cycle as clr_err keeps the flag set.
        overflow_d  = (overflow_q && !clr_err) || (write_en && full_q);
        underflow_d = (underflow_q && !clr_err) || (read_en && empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            amst_full_q  <= 1'b0;
            amst_empty_q <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            amst_full_q  <= amst_full_d;
            amst_empty_q <= amst_empty_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is deliberately left uninitialised by reset and flush.
    always_ff @(posedge clk) begin
        if (!rst && do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata  = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];
            assign rvalid = !empty_q;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
            logic                  rvalid_q, rvalid_d;

            always_comb begin
                rdata_d  = do_rd ? mem_q[rd_ptr_q[AW-1:0]] : rdata_q;
                rvalid_d = do_rd;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

    assign full       = full_q;
    assign empty      = empty_q;
    assign amst_full  = amst_full_q;
    assign amst_empty = amst_empty_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: registered-read and FWFT instances share one stimulus stream and
// are compared every cycle against a queue-based model, plus directed literal checks.
module tb_sync_fifo_prog;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst, flush, write_en, read_en, clr_err;
    logic [DW-1:0] wdata;
    logic [CW-1:0] af_level, ae_level;

    logic [DW-1:0] rdata0, rdata1;
    logic          rvalid0, full0, empty0, af0, ae0, ovf0, udf0;
    logic          rvalid1, full1, empty1, af1, ae1, ovf1, udf1;
    logic [CW-1:0] count0, count1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .write_en(write_en), .wdata(wdata),
        .read_en(read_en), .af_level(af_level), .ae_level(ae_level), .clr_err(clr_err),
        .rdata(rdata0), .rvalid(rvalid0), .full(full0), .empty(empty0),
        .amst_full(af0), .amst_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .write_en(write_en), .wdata(wdata),
        .read_en(read_en), .af_level(af_level), .ae_level(ae_level), .clr_err(clr_err),
        .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1),
        .amst_full(af1), .amst_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(udf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is the queue length, data order is the queue order.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata0;
    bit            m_rvalid0, m_ovf, m_udf, m_af, m_ae;
    bit            chk_en = 0;

    always @(posedge clk) begin : mdl
        int sz;
        bit wr_ok, rd_ok;
        if (rst) begin
            q.delete();
            m_rdata0  = '0;
            m_rvalid0 = 0;
            m_ovf     = 0;
            m_udf     = 0;
            m_af      = 0;
            m_ae      = 1;
            chk_en    = 1;
        end else begin
            sz    = q.size();
            wr_ok = write_en && (sz < DEPTH);
            rd_ok = read_en && (sz > 0);
            m_ovf = (m_ovf && !clr_err) || (write_en && sz == DEPTH);
            m_udf = (m_udf && !clr_err) || (read_en && sz == 0);
            if (flush) begin
                q.delete();
                m_rvalid0 = 0;
            end else begin
                m_rvalid0 = rd_ok;
                if (rd_ok) m_rdata0 = q.pop_front();
                if (wr_ok) q.push_back(wdata);
            end
            m_af = q.size() >= int'(af_level);
            m_ae = q.size() <= int'(ae_level);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count0", count0, q.size());
            chk("count1", count1, q.size());
            chk("full0", full0, q.size() == DEPTH);
            chk("full1", full1, q.size() == DEPTH);
            chk("empty0", empty0, q.size() == 0);
            chk("empty1", empty1, q.size() == 0);
            chk("amst_full0", af0, m_af);
            chk("amst_full1", af1, m_af);
            chk("amst_empty0", ae0, m_ae);
            chk("amst_empty1", ae1, m_ae);
            chk("overflow0", ovf0, m_ovf);
            chk("overflow1", ovf1, m_ovf);
            chk("underflow0", udf0, m_udf);
            chk("underflow1", udf1, m_udf);
            chk("rdata0", rdata0, m_rdata0);
            chk("rvalid0", rvalid0, m_rvalid0);
            chk("rvalid1", rvalid1, q.size() > 0);
            if (q.size() > 0) chk("rdata1", rdata1, q[0]);
        end
    end

    task automatic drv(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit f = 0, input bit c = 0);
        write_en = w;
        wdata    = d;
        read_en  = r;
        flush    = f;
        clr_err  = c;
        @(posedge clk);
        #1;
        write_en = 0;
        read_en  = 0;
        flush    = 0;
        clr_err  = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        rst = 1; flush = 0; write_en = 0; read_en = 0; clr_err = 0; wdata = '0;
        af_level = 5'd14;
        ae_level = 5'd2;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("reset_empty", empty0, 1);
        chk("reset_ae", ae0, 1);

        // Fill 0x00..0x0F, then one write too many.
        for (int i = 0; i < 16; i++) begin
            drv(1, 8'(i), 0);
            if (i == 12) chk("af_after13", af0, 0);
            if (i == 13) chk("af_after14", af0, 1);
        end
        chk("fill_full", full0, 1);
        chk("fill_count", count0, 16);
        drv(1, 8'hFF, 0);
        chk("ovf_set", ovf0, 1);
        chk("ovf_count", count0, 16);

        // Drain in order, then one read too many.
        for (int i = 0; i < 16; i++) begin
            drv(0, 0, 1);
            chk("drain_rdata", rdata0, i);
            chk("drain_rvalid", rvalid0, 1);
        end
        chk("drain_empty", empty0, 1);
        drv(0, 0, 1);
        chk("udf_set", udf0, 1);
        chk("udf_rdata_hold", rdata0, 8'h0F);
        chk("udf_rvalid", rvalid0, 0);
        drv(0, 0, 0, 0, 1);
        chk("clr_ovf", ovf0, 0);
        chk("clr_udf", udf0, 0);

        // Simultaneous read+write at count 5 and at count 0.
        for (int i = 0; i < 5; i++) drv(1, 8'(8'h20 + i), 0);
        drv(1, 8'h30, 1);
        chk("rw5_count", count0, 5);
        chk("rw5_rdata", rdata0, 8'h20);
        chk("rw5_ae", ae0, 0);
        chk("rw5_af", af0, 0);
        for (int i = 0; i < 5; i++) drv(0, 0, 1);
        chk("rw5_last", rdata0, 8'h30);
        drv(1, 8'h40, 1);
        chk("rw0_count", count0, 1);
        chk("rw0_udf", udf0, 1);
        drv(0, 0, 1);
        chk("rw0_rdata", rdata0, 8'h40);
        drv(0, 0, 0, 0, 1);

        // Interleaved push/pop across several pointer wraps.
        for (int i = 0; i < 40; i++) begin
            v = 8'(i * 3 + 1);
            drv(1, v, 0);
            drv(0, 0, 1);
            chk("wrap_rdata", rdata0, v);
        end

        // Flush at count 9 with a write present; overflow is retained.
        for (int i = 0; i < 17; i++) drv(1, 8'(8'h50 + i), 0);
        for (int i = 0; i < 7; i++) drv(0, 0, 1);
        chk("pre_flush_count", count0, 9);
        drv(1, 8'hEE, 0, 1);
        chk("flush_count", count0, 0);
        chk("flush_empty", empty0, 1);
        chk("flush_ae", ae0, 1);
        chk("flush_ovf", ovf0, 1);
        chk("flush_rvalid", rvalid0, 0);
        chk("flush_rdata_hold", rdata0, 8'h56);
        drv(0, 0, 0, 0, 1);
        chk("flush_clr", ovf0, 0);

        // FWFT visibility without a read.
        drv(1, 8'hA5, 0);
        chk("fwft_rvalid", rvalid1, 1);
        chk("fwft_rdata", rdata1, 8'hA5);
        drv(0, 0, 1);
        chk("fwft_empty", empty1, 1);
        chk("fwft_rvalid_low", rvalid1, 0);

        // Reset mid-operation at count 7 with sticky error set and a zero threshold.
        drv(0, 0, 1);
        for (int i = 0; i < 7; i++) drv(1, 8'(8'h60 + i), 0);
        chk("pre_rst_count", count0, 7);
        af_level = 5'd0;
        rst = 1; write_en = 1; read_en = 1; wdata = 8'h77;
        @(posedge clk);
        #1;
        rst = 0; write_en = 0; read_en = 0;
        af_level = 5'd14;
        chk("rst_count", count0, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_full", full0, 0);
        chk("rst_empty", empty1, 1);
        chk("rst_af", af0, 0);
        chk("rst_ae", ae1, 1);
        chk("rst_ovf", ovf1, 0);
        chk("rst_udf", udf0, 0);

        // Randomised traffic with phases biased toward filling, balance and draining.
        for (int n = 0; n < 4000; n++) begin
            int wp;
            wp = (((n / 200) % 3) == 0) ? 80 : ((((n / 200) % 3) == 1) ? 50 : 20);
            if ($urandom_range(0, 99) < 5) begin
                af_level = 5'($urandom_range(0, 16));
                ae_level = 5'($urandom_range(0, 16));
            end
            rst = ($urandom_range(0, 999) < 5);
            drv($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < (100 - wp),
                $urandom_range(0, 99) < 1, $urandom_range(0, 99) < 3);
            rst = 0;
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
